// File: rtl/ddr2_cmd_arb.sv
// Command-bus scheduler for the DDR2 controller: auto-refresh timer plus refresh/write/read grant FSM.
// Define DDR2_ARB_RR_EN for write/read round robin; the default build gives write fixed priority over read.
module ddr2_cmd_arb #(
    parameter int TREFI_CYC    = 1560,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       init_done,
    input  logic       wr_req,
    output logic       wr_ack,
    input  logic       wr_done,
    input  logic       rd_req,
    output logic       rd_ack,
    input  logic       rd_done,
    output logic       ref_start,
    input  logic       ref_done,
    output logic [3:0] ref_pending,
    output logic       ref_ovf,
    output logic [1:0] arb_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_REFRESH = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_timer;
    logic [3:0]  r_pend;
    logic        r_ovf;
    logic        r_wr_ack;
    logic        r_rd_ack;
    logic        r_ref_start;
    logic        w_tick;
    logic        w_pick_wr;

    assign w_tick = init_done && (r_timer == 16'(TREFI_CYC - 1));

    always_ff @(posedge ck) begin
        if (rst || !init_done || w_tick) r_timer <= 16'd0;
        else                             r_timer <= r_timer + 16'd1;
    end

    // The decrement lands in the cycle ref_start is visible, so a tick in that cycle cancels it.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_pend <= 4'd0;
            r_ovf  <= 1'b0;
        end else if (w_tick && !r_ref_start) begin
            if (r_pend == 4'(MAX_POSTPONE)) r_ovf  <= 1'b1;
            else                            r_pend <= r_pend + 4'd1;
        end else if (!w_tick && r_ref_start) begin
            r_pend <= r_pend - 4'd1;
        end
    end

`ifdef DDR2_ARB_RR_EN
    logic r_rr_wr;

    // Set means write wins the next tie.
    always_ff @(posedge ck) begin
        if (rst)           r_rr_wr <= 1'b1;
        else if (r_wr_ack) r_rr_wr <= 1'b0;
        else if (r_rd_ack) r_rr_wr <= 1'b1;
    end

    assign w_pick_wr = wr_req && (!rd_req || r_rr_wr);
`else
    assign w_pick_wr = wr_req;
`endif

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ack    <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_ref_start <= 1'b0;
        end else begin
            r_wr_ack    <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_ref_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (init_done) begin
                        if (r_pend != 4'd0) begin
                            r_state     <= S_REFRESH;
                            r_ref_start <= 1'b1;
                        end else if (w_pick_wr) begin
                            r_state  <= S_WRITE;
                            r_wr_ack <= 1'b1;
                        end else if (rd_req) begin
                            r_state  <= S_READ;
                            r_rd_ack <= 1'b1;
                        end
                    end
                end
                S_WRITE:   if (wr_done)  r_state <= S_IDLE;
                S_READ:    if (rd_done)  r_state <= S_IDLE;
                S_REFRESH: if (ref_done) r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_ack      = r_wr_ack;
    assign rd_ack      = r_rd_ack;
    assign ref_start   = r_ref_start;
    assign ref_pending = r_pend;
    assign ref_ovf     = r_ovf;
    assign arb_state   = r_state;

endmodule

// File: tb/tb_ddr2_cmd_arb.sv
// Bench for ddr2_cmd_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_ddr2_cmd_arb;
    localparam int TREFI = 16;
    localparam int MAXP  = 8;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       init_done = 1'b0;
    logic       wr_req = 1'b0, wr_done = 1'b0, rd_req = 1'b0, rd_done = 1'b0, ref_done = 1'b0;
    logic       wr_ack, rd_ack, ref_start, ref_ovf;
    logic [3:0] ref_pending;
    logic [1:0] arb_state;

    int n_chk = 0;
    int n_pass = 0;

    // Model: arb_state code, pending count, sticky overflow, grant pulses, tie winner.
    logic [1:0] m_state = 2'd0;
    int         m_pend = 0;
    int         m_tcnt = 0;
    bit         m_ovf = 0, m_wa = 0, m_ra = 0, m_rs = 0, m_wr_turn = 1;

    ddr2_cmd_arb #(.TREFI_CYC(TREFI), .MAX_POSTPONE(MAXP)) dut (
        .ck(ck), .rst(rst), .init_done(init_done),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_done(rd_done),
        .ref_start(ref_start), .ref_done(ref_done),
        .ref_pending(ref_pending), .ref_ovf(ref_ovf), .arb_state(arb_state)
    );

    always #5 ck = ~ck;

    // One clock of the spec's rules, applied to the inputs present at the edge.
    task automatic model_edge();
        bit         tick;
        logic [1:0] ns;
        bit         nwa, nra, nrs;
        if (rst) begin
            m_state = 2'd0; m_pend = 0; m_tcnt = 0; m_ovf = 0;
            m_wa = 0; m_ra = 0; m_rs = 0; m_wr_turn = 1;
            return;
        end
        tick = 0;
        if (!init_done) m_tcnt = 0;
        else begin
            m_tcnt++;
            if (m_tcnt == TREFI) begin tick = 1; m_tcnt = 0; end
        end
        ns = m_state; nwa = 0; nra = 0; nrs = 0;
        case (m_state)
            2'd0: if (init_done) begin
                if (m_pend > 0) begin ns = 2'd3; nrs = 1; end
                else if (wr_req && (!rd_req || m_wr_turn)) begin ns = 2'd1; nwa = 1; end
                else if (rd_req) begin ns = 2'd2; nra = 1; end
            end
            2'd1: if (wr_done) ns = 2'd0;
            2'd2: if (rd_done) ns = 2'd0;
            default: if (ref_done) ns = 2'd0;
        endcase
`ifdef DDR2_ARB_RR_EN
        if (m_wa) m_wr_turn = 0;
        if (m_ra) m_wr_turn = 1;
`endif
        if (tick && !m_rs) begin
            if (m_pend == MAXP) m_ovf = 1;
            else m_pend++;
        end else if (!tick && m_rs) m_pend--;
        m_state = ns; m_wa = nwa; m_ra = nra; m_rs = nrs;
    endtask

    task automatic step();
        @(posedge ck);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; init_done = 1'b0;
        step(); step();
        n_chk++;
        if ({arb_state, wr_ack, rd_ack, ref_start, ref_pending, ref_ovf} !== 10'd0)
            $display("FAIL reset_outputs: got %b want 0", {arb_state, wr_ack, rd_ack, ref_start, ref_pending, ref_ovf});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_init_gating();
        bit bad = 0;
        wr_req = 1'b1;
        repeat (40) begin
            step();
            if (wr_ack !== 1'b0 || ref_pending !== 4'd0 || arb_state !== 2'd0) bad = 1;
        end
        n_chk++;
        if (bad) $display("FAIL init_gating: got grant/pending activity=1 want 0");
        else n_pass++;
        init_done = 1'b1;
        step();
        n_chk++;
        if (wr_ack !== 1'b1 || arb_state !== 2'd1)
            $display("FAIL init_first_ack: got ack=%b state=%0d want ack=1 state=1", wr_ack, arb_state);
        else n_pass++;
        wr_req = 1'b0;
        step();
        n_chk++;
        if (wr_ack !== 1'b0) $display("FAIL ack_one_cycle: got %b want 0", wr_ack);
        else n_pass++;
        wr_done = 1'b1; step(); wr_done = 1'b0;
        n_chk++;
        if (arb_state !== 2'd0) $display("FAIL write_release: got %0d want 0", arb_state);
        else n_pass++;
    endtask

    task automatic test_periodic();
        int last = -1, cd = -1, n3 = 0, nref = 0;
        bit bad_gap = 0, bad_pend = 0;
        init_done = 1'b1; do_reset();
        for (int c = 0; c < 56; c++) begin
            ref_done = (cd == 0);
            step();
            ref_done = 1'b0;
            if (cd >= 0) cd--;
            if (ref_start === 1'b1) begin
                if (last >= 0 && c - last != TREFI) bad_gap = 1;
                if (last < 0 && c != TREFI) bad_gap = 1;
                last = c; cd = 5; nref++;
            end
            if (arb_state === 2'd3) n3++;
            if (ref_pending !== 4'(m_pend)) bad_pend = 1;
        end
        n_chk++;
        if (bad_gap || nref != 3) $display("FAIL periodic_spacing: got %0d refreshes gap_err=%0d want 3 at %0d-cycle spacing", nref, bad_gap, TREFI);
        else n_pass++;
        n_chk++;
        if (n3 != 18) $display("FAIL refresh_state_cycles: got %0d want 18", n3);
        else n_pass++;
        n_chk++;
        if (bad_pend) $display("FAIL periodic_pending: got mismatch vs model want none");
        else n_pass++;
    endtask

    task automatic test_postpone();
        logic [1:0] exp_seq [7] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd2};
        bit bad_seq = 0, rd_early = 0;
        init_done = 1'b1; do_reset();
        wr_req = 1'b1; step(); wr_req = 1'b0;
        repeat (50) step();
        n_chk++;
        if (ref_pending !== 4'd3 || arb_state !== 2'd1)
            $display("FAIL postpone_count: got pend=%0d state=%0d want pend=3 state=1", ref_pending, arb_state);
        else n_pass++;
        rd_req = 1'b1; wr_done = 1'b1; step(); wr_done = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            if (arb_state !== exp_seq[c]) bad_seq = 1;
            if (rd_ack === 1'b1 && ref_pending !== 4'd0) rd_early = 1;
            ref_done = ref_start;
            if (rd_ack === 1'b1) rd_req = 1'b0;
        end
        ref_done = 1'b0;
        n_chk++;
        if (bad_seq) $display("FAIL postpone_sequence: got wrong state sequence want 3,0,3,0,3,0,2");
        else n_pass++;
        n_chk++;
        if (rd_early || rd_req !== 1'b0) $display("FAIL read_after_refresh: got early=%0d unserved=%0d want 0,0", rd_early, rd_req);
        else n_pass++;
        rd_req = 1'b0;
        rd_done = 1'b1; step(); rd_done = 1'b0;
    endtask

    task automatic test_overflow();
        int nref = 0;
        init_done = 1'b1; do_reset();
        wr_req = 1'b1; step(); wr_req = 1'b0;
        repeat (150) step();
        n_chk++;
        if (ref_pending !== 4'd8 || ref_ovf !== 1'b1)
            $display("FAIL overflow_sat: got pend=%0d ovf=%b want pend=8 ovf=1", ref_pending, ref_ovf);
        else n_pass++;
        wr_done = 1'b1; step(); wr_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (ref_start === 1'b1) nref++;
            ref_done = ref_start;
        end
        ref_done = 1'b0;
        n_chk++;
        if (ref_ovf !== 1'b1 || nref < 8 || ref_pending !== 4'(m_pend))
            $display("FAIL overflow_sticky: got ovf=%b refs=%0d pend=%0d want ovf=1 refs>=8 pend=%0d", ref_ovf, nref, ref_pending, m_pend);
        else n_pass++;
        do_reset();
        n_chk++;
        if (ref_ovf !== 1'b0 || ref_pending !== 4'd0)
            $display("FAIL overflow_clear: got ovf=%b pend=%0d want 0,0", ref_ovf, ref_pending);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int got [$];
        int cd = -1, owner = 0;
        bit bad = 0;
`ifdef DDR2_ARB_RR_EN
        int exp_seq [4] = '{1, 2, 1, 2};
`else
        int exp_seq [4] = '{1, 1, 1, 1};
`endif
        init_done = 1'b1; do_reset();
        wr_req = 1'b1; rd_req = 1'b1;
        for (int c = 0; c < 16 && got.size() < 4; c++) begin
            wr_done = (cd == 0 && owner == 1);
            rd_done = (cd == 0 && owner == 2);
            step();
            wr_done = 1'b0; rd_done = 1'b0;
            if (cd >= 0) cd--;
            if (wr_ack === 1'b1) begin got.push_back(1); owner = 1; cd = 2; end
            if (rd_ack === 1'b1) begin got.push_back(2); owner = 2; cd = 2; end
        end
        if (got.size() != 4) bad = 1;
        else foreach (exp_seq[i]) if (got[i] != exp_seq[i]) bad = 1;
        n_chk++;
        if (bad) $display("FAIL arbitration_order: got %0d grants %p want %p", got.size(), got, exp_seq);
        else n_pass++;
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_midreset();
        init_done = 1'b1; do_reset();
        rd_req = 1'b1; step(); rd_req = 1'b0;
        repeat (3) step();
        n_chk++;
        if (arb_state !== 2'd2) $display("FAIL midreset_setup: got %0d want 2", arb_state);
        else n_pass++;
        do_reset();
        n_chk++;
        if ({arb_state, wr_ack, rd_ack, ref_start, ref_pending} !== 9'd0)
            $display("FAIL midreset_abort: got %b want 0", {arb_state, wr_ack, rd_ack, ref_start, ref_pending});
        else n_pass++;
        rd_done = 1'b1; step(); rd_done = 1'b0;
        n_chk++;
        if ({arb_state, wr_ack, rd_ack, ref_start} !== 5'd0)
            $display("FAIL stray_done: got %b want 0", {arb_state, wr_ack, rd_ack, ref_start});
        else n_pass++;
    endtask

    task automatic test_random();
        bit wb = 0, rb = 0, fb = 0;
        int wcd = 0, rcd = 0, fcd = 0;
        logic [9:0] got, exp;
        init_done = 1'b1; do_reset();
        for (int c = 0; c < 1500; c++) begin
            step();
            got = {arb_state, wr_ack, rd_ack, ref_start, ref_pending, ref_ovf};
            exp = {m_state, m_wa, m_ra, m_rs, 4'(m_pend), m_ovf};
            n_chk++;
            if (got !== exp) $display("FAIL random_cycle%0d: got %b want %b", c, got, exp);
            else n_pass++;
            if (wr_ack === 1'b1) begin wr_req = 1'b0; wb = 1; wcd = $urandom_range(0, 5); end
            if (rd_ack === 1'b1) begin rd_req = 1'b0; rb = 1; rcd = $urandom_range(0, 5); end
            if (ref_start === 1'b1) begin fb = 1; fcd = $urandom_range(0, 6); end
            wr_done = 1'b0; rd_done = 1'b0; ref_done = 1'b0;
            if (wb) begin if (wcd == 0) begin wr_done = 1'b1; wb = 0; end else wcd--; end
            if (rb) begin if (rcd == 0) begin rd_done = 1'b1; rb = 0; end else rcd--; end
            if (fb) begin if (fcd == 0) begin ref_done = 1'b1; fb = 0; end else fcd--; end
            if ($urandom_range(99) == 0) wr_done = 1'b1;
            if ($urandom_range(99) == 0) rd_done = 1'b1;
            if ($urandom_range(99) == 0) ref_done = 1'b1;
            if (!wb && !wr_req && $urandom_range(3) == 0) wr_req = 1'b1;
            if (!rb && !rd_req && $urandom_range(3) == 0) rd_req = 1'b1;
            if ($urandom_range(299) == 0) init_done = ~init_done;
            rst = ($urandom_range(699) == 0);
            if (rst) begin wb = 0; rb = 0; fb = 0; end
        end
        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_done = 1'b0; rd_done = 1'b0; ref_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_gating();
        test_periodic();
        test_postpone();
        test_overflow();
        test_arbitration();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr2_cmd_arb.md
Name: ddr2_cmd_arb

Overview:
- Scheduler in front of the DDR2 command sequencer in ddr2_ctrl.
- Owns the periodic auto-refresh timer and grants exclusive use of the command bus to one of three clients: refresh, write, read.
- Sits between the user-side request logic and the command FSM that drives ddr2_cs_n/ras_n/cas_n/we_n.
- Becomes active only after the init sequence reports done.

Parameters:
- TREFI_CYC, 1560, refresh interval in ck cycles (7.8 us at 200 MHz); legal range 4..65535.
- MAX_POSTPONE, 8, maximum number of outstanding refreshes the counter tracks (DDR2 limit).

Ports:
- ck  in  1  controller clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- init_done  in  1  level; high once the DDR2 init sequence has completed.
- wr_req  in  1  level; write client requests the bus, held until granted.
- wr_ack  out  1  one-cycle grant pulse to the write client.
- wr_done  in  1  one-cycle pulse; write burst plus tWR complete, releases the bus.
- rd_req  in  1  level; read client request.
- rd_ack  out  1  one-cycle grant pulse to the read client.
- rd_done  in  1  one-cycle pulse; read complete, releases the bus.
- ref_start  out  1  one-cycle pulse; command FSM must issue PRECHARGE-ALL followed by AUTO REFRESH.
- ref_done  in  1  one-cycle pulse; tRFC elapsed.
- ref_pending  out  4  number of outstanding refreshes, 0..MAX_POSTPONE.
- ref_ovf  out  1  sticky error flag: a refresh tick arrived while ref_pending == MAX_POSTPONE.
- arb_state  out  2  encoding: 0 IDLE, 1 WRITE, 2 READ, 3 REFRESH.

Behaviour:
- Reset:
  - All outputs are 0 and arb_state is IDLE.
  - Timer and pending counter are cleared.
  - Round-robin pointer points to write.
  - A reset asserted mid-operation aborts any grant immediately; no done input is required afterwards.
- Refresh timer:
  - Held at 0 while init_done is 0.
  - Otherwise counts 0..TREFI_CYC-1 and wraps.
  - The wrap cycle produces an internal tick.
- Pending counter:
  - A tick increments it, saturating at MAX_POSTPONE.
  - Issuing ref_start decrements it.
  - Tick and ref_start in the same cycle leave it unchanged.
  - A tick while at MAX_POSTPONE (and no ref_start that cycle) sets ref_ovf; ref_ovf clears only on rst.
- FSM, IDLE:
  - If init_done is 0, stay in IDLE and ignore all requests.
  - Otherwise evaluate in priority order:
    - ref_pending > 0: go to REFRESH.
    - Else a write or read request: go to WRITE or READ per the arbitration rule.
    - Else stay in IDLE.
  - Requests are sampled in IDLE only.
- Grant timing:
  - The first cycle in WRITE/READ/REFRESH asserts wr_ack/rd_ack/ref_start for exactly one cycle.
  - Latency from a request sampled in IDLE to its ack is 1 cycle.
- FSM, WRITE/READ/REFRESH:
  - Stay in the state until the matching done (wr_done/rd_done/ref_done) is sampled high; the next cycle is IDLE.
  - Done is honoured on the same cycle as the ack.
  - Done pulses that do not match the current state are ignored.
- At least one IDLE cycle separates consecutive grants.
- Refresh ticks arriving during WRITE/READ are accumulated and serviced at the next IDLE, ahead of pending data requests.
- arb_state is a registered copy of the FSM state.

Optional Feature:
- Macro: DDR2_ARB_RR_EN.
- Defined:
  - Write and read alternate by round robin.
  - When both are requested in IDLE, the client not served most recently wins.
  - The pointer updates on each wr_ack/rd_ack.
- Not defined:
  - Fixed priority, write over read; no pointer is implemented.
- Refresh priority is identical in both builds.

Test Plan:
- Init gating, TREFI_CYC=16: wr_req=1, init_done=0 for 40 cycles -> wr_ack never asserts, ref_pending=0. Then raise init_done -> wr_ack exactly 1 cycle later.
- Periodic refresh, TREFI_CYC=16, idle clients: ref_start pulses every 16 cycles. Return ref_done 5 cycles after each ref_start -> ref_pending toggles 1->0, arb_state shows 3 for 6 cycles.
- Postponement, TREFI_CYC=16: grant write, withhold wr_done for 50 cycles -> ref_pending reaches 3. After wr_done, three back-to-back refreshes each separated by one IDLE cycle; a pending rd_req is acked only after ref_pending=0.
- Overflow, TREFI_CYC=16, MAX_POSTPONE=8: hold write for 150 cycles -> ref_pending saturates at 8 and ref_ovf=1, which stays 1 after service until rst.
- Arbitration, wr_req=rd_req=1 continuously, done returned 2 cycles after each ack, no refresh due:
  - With DDR2_ARB_RR_EN: acks alternate W,R,W,R.
  - Without it: only W.
- Mid-operation reset: rst for 1 cycle during READ -> next cycle arb_state=0, all acks 0, ref_pending=0; a following rd_done pulse causes no state change.
